fifo_write_arbiter: RTL

Write-side arbiter that shares one asynchronous FIFO write port among `NUM_REQ` producers in the write clock domain. It grants the port round-robin in bursts, which are bounded by a per-requester `last` flag or by `MAX_BURST` beats. It tags each written word with the source ID and never issues a write while the FIFO reports full, so no data is lost. It sits between the producer blocks and the FIFO's `write_enable`/`write_data`/`fifo_full` pins.

---
 rtl/fifo_write_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among NUM_REQ
// producers; tags each word with its source ID and never writes while full.
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                           write_clk,
  input  logic                           write_rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           fifo_full,
  output logic                           fifo_write_enable,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_write_data,
  output logic [ID_WIDTH-1:0]            grant_id,
  output logic                           busy
);

  localparam int unsigned ID_SPAN = 1 << ID_WIDTH;
  localparam int unsigned CNT_W   = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0]    BEAT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_WIDTH-1:0] LAST_INIT = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;

  logic                  xfer_c;
  logic [ID_SPAN-1:0]    ready_ext;
  logic                  win_found;
  logic [ID_WIDTH-1:0]   win_id;
  int unsigned           cand;

  // Requester vectors widened to the full ID space so grant_id indexes them directly
  logic [ID_SPAN-1:0]    valid_ext;
  logic [ID_SPAN-1:0]    last_ext;
  logic [DATA_WIDTH-1:0] data_arr [ID_SPAN];

  assign valid_ext = ID_SPAN'(req_valid);
  assign last_ext  = ID_SPAN'(req_last);

  for (genvar g = 0; g < ID_SPAN; g++) begin : g_data
    if (g < NUM_REQ) begin : g_real
      assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign data_arr[g] = '0;
    end
  end

  // State register; reset gives requester 0 first priority
  always_ff @(posedge write_clk or negedge write_rst) begin
    if (!write_rst) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= LAST_INIT;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Next state: round-robin scan in IDLE, locked burst with beat limit in BURST
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    win_found    = 1'b0;
    win_id       = '0;
    cand         = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 32'(last_grant_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && valid_ext[ID_WIDTH'(cand)]) begin
        win_found = 1'b1;
        win_id    = ID_WIDTH'(cand);
      end
    end
    if (state_q == IDLE) begin
      if (win_found) begin
        grant_id_d = win_id;
        beat_cnt_d = '0;
        state_d    = BURST;
      end
    end else if (xfer_c) begin
      if (last_ext[grant_id_q] || (beat_cnt_q == BEAT_LAST)) begin
        state_d      = IDLE;
        last_grant_d = grant_id_q;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  // Outputs: same-cycle write path so fifo_full gates the strobe immediately
  always_comb begin
    xfer_c            = 1'b0;
    ready_ext         = '0;
    fifo_write_enable = 1'b0;
    busy              = 1'b0;
    fifo_write_data   = {grant_id_q, data_arr[grant_id_q]};
    if (state_q == BURST) begin
      busy              = 1'b1;
      xfer_c            = valid_ext[grant_id_q] & ~fifo_full;
      fifo_write_enable = xfer_c;
      ready_ext         = ID_SPAN'(xfer_c) << grant_id_q;
    end
    req_ready = ready_ext[NUM_REQ-1:0];
  end

  assign grant_id = grant_id_q;

endmodule
